// File: rtl/ula_exec_stage.sv
// ula_exec_stage: registered ALU execute stage with a 2-entry (output + skid) buffer
// behind a valid/ready handshake.
`default_nettype none

module ula_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRSTn,
  input  logic [4:0]       iControl,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iValid,
  output logic             oReady,
  output logic [WIDTH-1:0] oResult,
  output logic             oZero,
  output logic             oIllegal,
  output logic             oValid,
  input  logic             iReady
);

  localparam logic [4:0] C_OP_AND  = 5'b00000;
  localparam logic [4:0] C_OP_OR   = 5'b00001;
  localparam logic [4:0] C_OP_ADD  = 5'b00011;
  localparam logic [4:0] C_OP_SUB  = 5'b00100;
  localparam logic [4:0] C_OP_SLT  = 5'b00101;
  localparam logic [4:0] C_OP_ZERO = 5'b11111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state, next_state;
  logic             accept, drain;
  logic             load_out_in, load_out_skid, load_skid;

  logic [WIDTH-1:0] calc_result;
  logic             calc_illegal;
  logic             calc_zero;
  logic             calc_slt;

  logic [WIDTH-1:0] out_result, skid_result;
  logic             out_zero, skid_zero;
  logic             out_illegal, skid_illegal;

  // Ready depends only on the registered state, never on iReady.
  assign oReady   = (state != TWO);
  assign oValid   = (state != EMPTY);
  assign oResult  = out_result;
  assign oZero    = out_zero;
  assign oIllegal = out_illegal;

  assign accept = iValid && oReady;
  assign drain  = oValid && iReady;

  assign calc_slt  = ($signed(iA) < $signed(iB));
  assign calc_zero = (calc_result == '0);

  always_comb begin
    calc_result  = '0;
    calc_illegal = 1'b0;
    case (iControl)
      C_OP_AND:  calc_result = iA & iB;
      C_OP_OR:   calc_result = iA | iB;
      C_OP_ADD:  calc_result = iA + iB;
      C_OP_SUB:  calc_result = iA - iB;
      C_OP_SLT:  calc_result = {{(WIDTH-1){1'b0}}, calc_slt};
      C_OP_ZERO: calc_result = '0;
      default:   calc_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          next_state  = ONE;
          load_out_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_out_in = 1'b1;
        end else if (accept) begin
          next_state = TWO;
          load_skid  = 1'b1;
        end else if (drain) begin
          next_state = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          next_state    = ONE;
          load_out_skid = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_illegal  <= 1'b0;
      skid_result  <= '0;
      skid_zero    <= 1'b0;
      skid_illegal <= 1'b0;
    end else begin
      if (load_out_in) begin
        out_result  <= calc_result;
        out_zero    <= calc_zero;
        out_illegal <= calc_illegal;
      end else if (load_out_skid) begin
        out_result  <= skid_result;
        out_zero    <= skid_zero;
        out_illegal <= skid_illegal;
      end
      if (load_skid) begin
        skid_result  <= calc_result;
        skid_zero    <= calc_zero;
        skid_illegal <= calc_illegal;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ula_exec_stage.sv
// tb_ula_exec_stage: directed vectors plus a randomized handshake stream checked
// against an independent queue model.
`default_nettype none

module tb_ula_exec_stage;

  logic        iCLK = 1'b0;
  logic        iRSTn;
  logic [4:0]  iControl;
  logic [31:0] iA, iB;
  logic        iValid;
  logic        oReady;
  logic [31:0] oResult;
  logic        oZero;
  logic        oIllegal;
  logic        oValid;
  logic        iReady;

  int n_vec = 0;
  int n_err = 0;

  ula_exec_stage #(.WIDTH(32)) dut (
    .iCLK     (iCLK),
    .iRSTn    (iRSTn),
    .iControl (iControl),
    .iA       (iA),
    .iB       (iB),
    .iValid   (iValid),
    .oReady   (oReady),
    .oResult  (oResult),
    .oZero    (oZero),
    .oIllegal (oIllegal),
    .oValid   (oValid),
    .iReady   (iReady)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic drive(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    iControl = c;
    iA       = a;
    iB       = b;
    iValid   = 1'b1;
  endtask

  // Drive one op with iReady=1 in steady state and check it one cycle later.
  task automatic op_check(input string tag, input logic [4:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res,
                          input logic z, input logic ill);
    drive(c, a, b);
    step();
    iValid = 1'b0;
    check({tag, ".valid"}, {31'd0, oValid}, 32'd1);
    check({tag, ".result"}, oResult, res);
    check({tag, ".zero"}, {31'd0, oZero}, {31'd0, z});
    check({tag, ".illegal"}, {31'd0, oIllegal}, {31'd0, ill});
  endtask

  // Independent reference: {illegal, zero, result}.
  function automatic logic [33:0] model(input logic [4:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic        ill;
    r   = 32'd0;
    ill = 1'b0;
    if (c == 5'd0)        r = a & b;
    else if (c == 5'd1)   r = a | b;
    else if (c == 5'd3)   r = a + b;
    else if (c == 5'd4)   r = a - b;
    else if (c == 5'd5)   r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
    else if (c == 5'd31)  r = 32'd0;
    else                  ill = 1'b1;
    return {ill, (r == 32'd0), r};
  endfunction

  initial begin
    logic [33:0] q[$];
    logic [33:0] e;
    logic [4:0]  legal [6];
    int          sent;
    int          cyc;
    logic        in_x, out_x;

    legal = '{5'd0, 5'd1, 5'd3, 5'd4, 5'd5, 5'd31};
    iRSTn = 1'b0; iControl = 5'd0; iA = 32'd0; iB = 32'd0; iValid = 1'b0; iReady = 1'b1;
    #12;
    check("rst.valid", {31'd0, oValid}, 32'd0);
    check("rst.result", oResult, 32'd0);
    check("rst.zero", {31'd0, oZero}, 32'd0);
    check("rst.illegal", {31'd0, oIllegal}, 32'd0);
    step();
    iRSTn = 1'b1;
    step();
    check("rel.ready", {31'd0, oReady}, 32'd1);
    check("rel.valid", {31'd0, oValid}, 32'd0);

    op_check("add5_7", 5'b00011, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    op_check("sub3_5", 5'b00100, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0);
    op_check("sub9_9", 5'b00100, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
    op_check("slt_m1_1", 5'b00101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    op_check("slt_1_m1", 5'b00101, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    op_check("add_wrap", 5'b00011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    op_check("illegal", 5'b01010, 32'd7, 32'd7, 32'd0, 1'b1, 1'b1);
    op_check("zero_op", 5'b11111, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0);
    op_check("and", 5'b00000, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0);
    op_check("or", 5'b00001, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0);
    step();
    check("drained.valid", {31'd0, oValid}, 32'd0);

    // Backpressure: fill output + skid, third op must stall.
    iReady = 1'b0;
    drive(5'b00000, 32'hF0, 32'h3C);
    step();
    drive(5'b00001, 32'hF0, 32'h0F);
    check("bp.ready1", {31'd0, oReady}, 32'd1);
    step();
    drive(5'b00011, 32'd1, 32'd1);
    check("bp.ready_full", {31'd0, oReady}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp.hold_result", oResult, 32'h30);
      check("bp.hold_valid", {31'd0, oValid}, 32'd1);
      check("bp.hold_ready", {31'd0, oReady}, 32'd0);
    end
    iReady = 1'b1;
    step();
    check("bp.out2", oResult, 32'hFF);
    step();
    iValid = 1'b0;
    check("bp.out3", oResult, 32'd2);
    check("bp.out3_valid", {31'd0, oValid}, 32'd1);
    step();
    check("bp.empty", {31'd0, oValid}, 32'd0);

    // Reset while both entries are occupied.
    iReady = 1'b0;
    drive(5'b00011, 32'd10, 32'd20);
    step();
    drive(5'b00011, 32'd30, 32'd40);
    step();
    iValid = 1'b0;
    check("two.ready", {31'd0, oReady}, 32'd0);
    #2;
    iRSTn = 1'b0;
    #1;
    check("midrst.valid", {31'd0, oValid}, 32'd0);
    check("midrst.ready", {31'd0, oReady}, 32'd1);
    check("midrst.result", oResult, 32'd0);
    step();
    iRSTn = 1'b1;
    iReady = 1'b1;
    step();
    check("postrst.valid", {31'd0, oValid}, 32'd0);
    check("postrst.ready", {31'd0, oReady}, 32'd1);
    step();
    check("postrst.stale", {31'd0, oValid}, 32'd0);

    // Random stream against the queue model.
    sent = 0;
    cyc  = 0;
    while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
      iValid = (sent < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
      iReady = ($urandom_range(0, 2) != 0);
      iControl = ($urandom_range(0, 7) < 6) ? legal[$urandom_range(0, 5)] : 5'($urandom);
      iA = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      iB = ($urandom_range(0, 3) == 0) ? iA : $urandom;
      check("rnd.valid", {31'd0, oValid}, {31'd0, q.size() != 0});
      check("rnd.ready", {31'd0, oReady}, {31'd0, q.size() < 2});
      if (q.size() != 0) begin
        e = q[0];
        check("rnd.result", oResult, e[31:0]);
        check("rnd.flags", {30'd0, oIllegal, oZero}, {30'd0, e[33], e[32]});
      end
      in_x  = iValid && (q.size() < 2);
      out_x = iReady && (q.size() != 0);
      e = model(iControl, iA, iB);
      step();
      if (out_x) void'(q.pop_front());
      if (in_x) begin
        q.push_back(e);
        sent++;
      end
      cyc++;
    end
    iValid = 1'b0;
    check("rnd.completed", 32'(sent), 32'd1000);
    check("rnd.queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
